// File: rtl/game_flow_ctrl_if.sv
// Event/pulse/status bundle between the auto-pets datapath (master) and game_flow_ctrl (slave).
interface game_flow_ctrl_if #(
    parameter int unsigned LIVES           = 5,
    parameter int unsigned WINS_TO_VICTORY = 10,
    parameter int unsigned TURN_W          = 5,
    parameter int unsigned OFF_W           = 12
);
    localparam int unsigned LIVES_W = $clog2(LIVES + 1);
    localparam int unsigned WINS_W  = $clog2(WINS_TO_VICTORY + 1);

    logic               start;
    logic               team_ready;
    logic               action_fight;
    logic               battle_done;
    logic               battle_win;
    logic               battle_tie;
    logic               pause_req;

    logic               load_regs;
    logic               decr_lives;
    logic               rewards;
    logic               battle_timeout;
    logic [2:0]         ps;
    logic [2:0]         ns;
    logic [LIVES_W-1:0] lives;
    logic [WINS_W-1:0]  wins;
    logic [TURN_W-1:0]  turn;
    logic [OFF_W-1:0]   read_off;

    modport master (
        output start, team_ready, action_fight, battle_done, battle_win, battle_tie, pause_req,
        input  load_regs, decr_lives, rewards, battle_timeout, ps, ns, lives, wins, turn, read_off
    );

    modport slave (
        input  start, team_ready, action_fight, battle_done, battle_win, battle_tie, pause_req,
        output load_regs, decr_lives, rewards, battle_timeout, ps, ns, lives, wins, turn, read_off
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Auto-pets game-flow FSM: lives/wins/turn counters, battle watchdog, screen ROM offset.
// Optional pause state enabled by defining GAME_PAUSE_EN.
module game_flow_ctrl #(
    parameter int unsigned LIVES           = 5,
    parameter int unsigned WINS_TO_VICTORY = 10,
    parameter int unsigned SCREEN_H        = 480,
    parameter int unsigned OFF_W           = 12,
    parameter int unsigned BATTLE_TIMEOUT  = 1023,
    parameter int unsigned TURN_W          = 5
) (
    input  logic            clk,
    input  logic            reset,
    game_flow_ctrl_if.slave bus
);
    localparam int unsigned LIVES_W = $clog2(LIVES + 1);
    localparam int unsigned WINS_W  = $clog2(WINS_TO_VICTORY + 1);
    localparam int unsigned WD_W    = (BATTLE_TIMEOUT > 1) ? $clog2(BATTLE_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_SETUP   = 3'd1,
        S_PLAN    = 3'd2,
        S_BATTLE  = 3'd3,
        S_DEAD    = 3'd4,
        S_VICTORY = 3'd5,
        S_PAUSE   = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [WINS_W-1:0]    wins_q, wins_d;
    logic [TURN_W-1:0]    turn_q, turn_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [OFF_W-1:0]     read_off_q;

    logic in_battle_c, wd_hit_c, win_c, tie_c, loss_c, exit_c, last_win_c, pause_hit_c;
    logic load_regs_c, decr_lives_c, rewards_c, battle_timeout_c;

    // Screen index to ROM offset; PAUSE shares code and index 6.
    function automatic logic [OFF_W-1:0] screen_off(input state_e s);
        int unsigned idx;
        case (s)
            S_SETUP:   idx = 1;
            S_PLAN:    idx = 3;
            S_BATTLE:  idx = 4;
            S_DEAD:    idx = 2;
            S_VICTORY: idx = 5;
            S_PAUSE:   idx = 6;
            default:   idx = 0;
        endcase
        return OFF_W'(idx * SCREEN_H);
    endfunction

    // Battle outcome decode; battle_done always outranks the watchdog and pause.
    assign in_battle_c = (state_q == S_BATTLE);
    assign wd_hit_c    = (BATTLE_TIMEOUT != 0) && (wd_q == WD_W'(BATTLE_TIMEOUT - 1));
    assign win_c       = in_battle_c && bus.battle_done && bus.battle_win;
    assign tie_c       = in_battle_c && bus.battle_done && !bus.battle_win && bus.battle_tie;
    assign loss_c      = in_battle_c && ((bus.battle_done && !bus.battle_win && !bus.battle_tie)
                                         || (!bus.battle_done && wd_hit_c));
    assign exit_c      = in_battle_c && (bus.battle_done || wd_hit_c);
    assign last_win_c  = ((wins_q + WINS_W'(1)) == WINS_W'(WINS_TO_VICTORY));

`ifdef GAME_PAUSE_EN
    state_e pause_ret_q, pause_ret_d;

    assign pause_hit_c = bus.pause_req && ((state_q == S_PLAN) || in_battle_c) && !exit_c;
    assign pause_ret_d = pause_hit_c ? state_q : pause_ret_q;

    always_ff @(posedge clk) begin
        if (reset) pause_ret_q <= S_PLAN;
        else       pause_ret_q <= pause_ret_d;
    end
`else
    logic unused_pause_req;

    assign pause_hit_c      = 1'b0;
    assign unused_pause_req = bus.pause_req;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_START;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START: if (bus.start) state_d = S_SETUP;
            S_SETUP: if (bus.team_ready) state_d = S_PLAN;
            S_PLAN: begin
                if (pause_hit_c)           state_d = S_PAUSE;
                else if (bus.action_fight) state_d = S_BATTLE;
            end
            S_BATTLE: begin
                if (win_c)            state_d = last_win_c ? S_VICTORY : S_PLAN;
                else if (tie_c)       state_d = S_PLAN;
                else if (loss_c)      state_d = (lives_q <= LIVES_W'(1)) ? S_DEAD : S_PLAN;
                else if (pause_hit_c) state_d = S_PAUSE;
            end
            S_DEAD, S_VICTORY: if (bus.start) state_d = S_START;
            S_PAUSE: begin
`ifdef GAME_PAUSE_EN
                if (bus.pause_req) state_d = pause_ret_q;
`else
                state_d = S_START;
`endif
            end
            default: state_d = S_START;
        endcase
    end

    // Mealy pulse outputs.
    always_comb begin
        load_regs_c      = 1'b0;
        decr_lives_c     = 1'b0;
        rewards_c        = 1'b0;
        battle_timeout_c = 1'b0;
        if (state_q == S_START && bus.start) load_regs_c = 1'b1;
        if (loss_c)                          decr_lives_c = 1'b1;
        if (exit_c && state_d == S_PLAN)     rewards_c = 1'b1;
        if (in_battle_c && !bus.battle_done && wd_hit_c) battle_timeout_c = 1'b1;
    end

    // Counter next values.
    always_comb begin
        lives_d = lives_q;
        wins_d  = wins_q;
        turn_d  = turn_q;
        wd_d    = wd_q;
        if (load_regs_c) begin
            lives_d = LIVES_W'(LIVES);
            wins_d  = '0;
            turn_d  = '0;
        end
        if (decr_lives_c && lives_q != '0) lives_d = lives_q - LIVES_W'(1);
        if (win_c && wins_q < WINS_W'(WINS_TO_VICTORY)) wins_d = wins_q + WINS_W'(1);
        if (exit_c && turn_q != '1) turn_d = turn_q + TURN_W'(1);
        // Watchdog clears on a fresh fight, runs only while staying in BATTLE, holds in PAUSE.
        if (state_q == S_PLAN && state_d == S_BATTLE)
            wd_d = '0;
        else if (BATTLE_TIMEOUT != 0 && in_battle_c && state_d == S_BATTLE)
            wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lives_q    <= LIVES_W'(LIVES);
            wins_q     <= '0;
            turn_q     <= '0;
            wd_q       <= '0;
            read_off_q <= '0;
        end else begin
            lives_q    <= lives_d;
            wins_q     <= wins_d;
            turn_q     <= turn_d;
            wd_q       <= wd_d;
            read_off_q <= screen_off(state_d);
        end
    end

    assign bus.load_regs      = load_regs_c;
    assign bus.decr_lives     = decr_lives_c;
    assign bus.rewards        = rewards_c;
    assign bus.battle_timeout = battle_timeout_c;
    assign bus.ps             = state_q;
    assign bus.ns             = state_d;
    assign bus.lives          = lives_q;
    assign bus.wins           = wins_q;
    assign bus.turn           = turn_q;
    assign bus.read_off       = read_off_q;
endmodule
